// File: rtl/fifo_level_pkg.sv
// -----------------------------------------------------------------------------
// fifo_level_pkg
// Shared sizing helpers for every FIFO instance on the I2C/APB path.
// Depth and pointer width are derived here so that all FIFOs agree on how
// an ADDRESS_SIZE parameter turns into storage depth and pointer bits.
//
// Contents:
//   DEFAULT_DATA_SIZE     default word width in bits
//   DEFAULT_ADDRESS_SIZE  default log2 of depth
//   fifoDepth()           2**addressSize
//   ptrWidth()            addressSize + 1 (extra MSB separates full from empty)
// -----------------------------------------------------------------------------
package fifo_level_pkg;

    localparam int DEFAULT_DATA_SIZE    = 8;
    localparam int DEFAULT_ADDRESS_SIZE = 3;

    // Number of storage words for a given address width.
    function automatic int fifoDepth(input int addressSize);
        return 1 << addressSize;
    endfunction

    // Pointers carry one extra bit that toggles on every wrap, so equal low
    // bits with differing MSBs means full and identical pointers mean empty.
    function automatic int ptrWidth(input int addressSize);
        return addressSize + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Dual-port storage array for fifo_level: one synchronous write port and one
// asynchronous read port. The array is deliberately not reset.
//
// Ports:
//   clk        rising-edge clock for the write port
//   wrEn_i     write enable
//   wrAddr_i   write address (ADDRESS_SIZE bits)
//   wrData_i   write data (DATA_SIZE bits)
//   rdAddr_i   read address (ADDRESS_SIZE bits)
//   rdData_o   combinational read data at rdAddr_i
// -----------------------------------------------------------------------------
module fifo_mem
    import fifo_level_pkg::*;
#(
    parameter int DATA_SIZE    = DEFAULT_DATA_SIZE,
    parameter int ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE
) (
    input  logic                    clk,
    input  logic                    wrEn_i,
    input  logic [ADDRESS_SIZE-1:0] wrAddr_i,
    input  logic [DATA_SIZE-1:0]    wrData_i,
    input  logic [ADDRESS_SIZE-1:0] rdAddr_i,
    output logic [DATA_SIZE-1:0]    rdData_o
);

    localparam int DEPTH = fifoDepth(ADDRESS_SIZE);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    // Write port: storage has no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
    end

    // Asynchronous read port feeds both the registered and the
    // first-word-fall-through output paths in the parent.
    assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/fifo_level.sv
// -----------------------------------------------------------------------------
// fifo_level
// Synchronous FIFO with registered level count, full/empty and threshold
// flags, sticky overflow/underflow, synchronous flush and an optional
// first-word-fall-through read path.
//
// Parameters:
//   DATA_SIZE     word width
//   ADDRESS_SIZE  log2 of depth
//   AF_LEVEL      ALMOST_FULL when LEVEL >= AF_LEVEL
//   AE_LEVEL      ALMOST_EMPTY when LEVEL <= AE_LEVEL
//   FWFT          0 = DATA_OUT loaded on the read edge, 1 = head word shown
//
// Ports:
//   clk, reset                clock, asynchronous active-high reset
//   CLEAR                     synchronous flush, wins over W_ENA/R_ENA
//   W_ENA, DATA_IN            write request and data
//   R_ENA, DATA_OUT           read request and data
//   WRITE_FULL, READ_EMPTY    LEVEL == DEPTH, LEVEL == 0
//   ALMOST_FULL, ALMOST_EMPTY threshold flags
//   LEVEL                     stored word count 0..DEPTH
//   OVERFLOW, UNDERFLOW       sticky error flags, cleared by CLEAR or reset
// -----------------------------------------------------------------------------
module fifo_level
    import fifo_level_pkg::*;
#(
    parameter int DATA_SIZE    = DEFAULT_DATA_SIZE,
    parameter int ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE,
    parameter int AF_LEVEL     = fifoDepth(ADDRESS_SIZE) - 1,
    parameter int AE_LEVEL     = 1,
    parameter int FWFT         = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CLEAR,
    input  logic                  W_ENA,
    input  logic                  R_ENA,
    input  logic [DATA_SIZE-1:0]  DATA_IN,
    output logic [DATA_SIZE-1:0]  DATA_OUT,
    output logic                  WRITE_FULL,
    output logic                  READ_EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [ADDRESS_SIZE:0] LEVEL,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int DEPTH = fifoDepth(ADDRESS_SIZE);
    localparam int PTR_W = ptrWidth(ADDRESS_SIZE);

    typedef logic [PTR_W-1:0] ptr_t;

    localparam ptr_t DEPTH_LVL = ptr_t'(DEPTH);
    localparam ptr_t AF_LVL    = ptr_t'(AF_LEVEL);
    localparam ptr_t AE_LVL    = ptr_t'(AE_LEVEL);

    ptr_t wrPtr_q, wrPtr_d;
    ptr_t rdPtr_q, rdPtr_d;
    ptr_t level_q, level_d;
    logic full_q, full_d;
    logic empty_q, empty_d;
    logic almostFull_q, almostFull_d;
    logic almostEmpty_q, almostEmpty_d;
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;
    logic [DATA_SIZE-1:0] dataOut_q, dataOut_d;

    logic wrAccept;
    logic rdAccept;
    logic memWrEn;
    logic [DATA_SIZE-1:0] memRdData;

    // Acceptance uses the registered flags, i.e. the state at the start of
    // the cycle, so a simultaneous read cannot make room for a write on a
    // full FIFO (and vice versa on an empty one).
    assign wrAccept = W_ENA && !full_q;
    assign rdAccept = R_ENA && !empty_q;
    assign memWrEn  = wrAccept && !CLEAR;

    fifo_mem #(
        .DATA_SIZE    (DATA_SIZE),
        .ADDRESS_SIZE (ADDRESS_SIZE)
    ) u_mem (
        .clk      (clk),
        .wrEn_i   (memWrEn),
        .wrAddr_i (wrPtr_q[ADDRESS_SIZE-1:0]),
        .wrData_i (DATA_IN),
        .rdAddr_i (rdPtr_q[ADDRESS_SIZE-1:0]),
        .rdData_o (memRdData)
    );

    // Next-state logic. CLEAR flushes pointers, count and error flags but
    // leaves the read data register alone. Flags are derived from the next
    // level so they are registered alongside it.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        dataOut_d   = dataOut_q;

        if (CLEAR) begin
            wrPtr_d     = '0;
            rdPtr_d     = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wrAccept) begin
                wrPtr_d = wrPtr_q + ptr_t'(1);
            end
            if (rdAccept) begin
                rdPtr_d   = rdPtr_q + ptr_t'(1);
                dataOut_d = memRdData;
            end
            case ({wrAccept, rdAccept})
                2'b10:   level_d = level_q + ptr_t'(1);
                2'b01:   level_d = level_q - ptr_t'(1);
                default: level_d = level_q;
            endcase
            overflow_d  = overflow_q  || (W_ENA && full_q);
            underflow_d = underflow_q || (R_ENA && empty_q);
        end

        full_d        = (level_d == DEPTH_LVL);
        empty_d       = (level_d == '0);
        almostFull_d  = (level_d >= AF_LVL);
        almostEmpty_d = (level_d <= AE_LVL);
    end

    // State registers; the storage array itself lives in fifo_mem and is
    // not touched by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            level_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            almostFull_q  <= 1'b0;
            almostEmpty_q <= 1'b1;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            dataOut_q     <= '0;
        end else begin
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            level_q       <= level_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            almostFull_q  <= almostFull_d;
            almostEmpty_q <= almostEmpty_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
            dataOut_q     <= dataOut_d;
        end
    end

    // In fall-through mode the head word is shown straight from the array
    // while the FIFO holds data; zero is driven while empty so the output
    // matches the reset value instead of stale storage.
    assign DATA_OUT     = (FWFT != 0) ? (empty_q ? '0 : memRdData) : dataOut_q;
    assign WRITE_FULL   = full_q;
    assign READ_EMPTY   = empty_q;
    assign ALMOST_FULL  = almostFull_q;
    assign ALMOST_EMPTY = almostEmpty_q;
    assign LEVEL        = level_q;
    assign OVERFLOW     = overflow_q;
    assign UNDERFLOW    = underflow_q;

endmodule

// File: tb/tb_fifo_level.sv
// -----------------------------------------------------------------------------
// tb_fifo_level
// Drives a registered-read instance and a fall-through instance of
// fifo_level with identical stimulus and compares both against a queue
// based reference model of the FIFO rules.
// -----------------------------------------------------------------------------
module tb_fifo_level;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
    localparam int AF    = DEPTH - 1;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          CLEAR = 1'b0;
    logic          W_ENA = 1'b0;
    logic          R_ENA = 1'b0;
    logic [DW-1:0] DATA_IN = '0;

    logic [DW-1:0] dout0, dout1;
    logic          full0, empty0, af0, ae0, ovf0, unf0;
    logic          full1, empty1, af1, ae1, ovf1, unf1;
    logic [AW:0]   level0, level1;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DW-1:0] modelQ[$];
    logic          modelOvf;
    logic          modelUnf;
    logic [DW-1:0] modelDout0;

    fifo_level #(.DATA_SIZE(DW), .ADDRESS_SIZE(AW), .FWFT(0)) dut0 (
        .clk(clk), .reset(reset), .CLEAR(CLEAR), .W_ENA(W_ENA), .R_ENA(R_ENA),
        .DATA_IN(DATA_IN), .DATA_OUT(dout0), .WRITE_FULL(full0),
        .READ_EMPTY(empty0), .ALMOST_FULL(af0), .ALMOST_EMPTY(ae0),
        .LEVEL(level0), .OVERFLOW(ovf0), .UNDERFLOW(unf0)
    );

    fifo_level #(.DATA_SIZE(DW), .ADDRESS_SIZE(AW), .FWFT(1)) dut1 (
        .clk(clk), .reset(reset), .CLEAR(CLEAR), .W_ENA(W_ENA), .R_ENA(R_ENA),
        .DATA_IN(DATA_IN), .DATA_OUT(dout1), .WRITE_FULL(full1),
        .READ_EMPTY(empty1), .ALMOST_FULL(af1), .ALMOST_EMPTY(ae1),
        .LEVEL(level1), .OVERFLOW(ovf1), .UNDERFLOW(unf1)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    // Model reset: empty queue, clear error flags and read register.
    task automatic modelReset();
        modelQ.delete();
        modelOvf   = 1'b0;
        modelUnf   = 1'b0;
        modelDout0 = '0;
    endtask

    // One clock edge of the FIFO rules, judged on start-of-cycle occupancy.
    task automatic modelStep(input logic clr, input logic w, input logic r,
                             input logic [DW-1:0] din);
        bit wasFull;
        bit wasEmpty;
        if (clr) begin
            modelQ.delete();
            modelOvf = 1'b0;
            modelUnf = 1'b0;
        end else begin
            wasFull  = (modelQ.size() == DEPTH);
            wasEmpty = (modelQ.size() == 0);
            if (r && !wasEmpty) begin
                modelDout0 = modelQ.pop_front();
            end
            if (w && !wasFull) begin
                modelQ.push_back(din);
            end
            if (w && wasFull) modelOvf = 1'b1;
            if (r && wasEmpty) modelUnf = 1'b1;
        end
    endtask

    // Compare every observable output of both instances with the model.
    task automatic checkState(input string where);
        int lvl;
        logic [DW-1:0] head;
        lvl  = modelQ.size();
        head = (lvl > 0) ? modelQ[0] : '0;
        checkOutput({where, ":level"},  32'(level0), 32'(lvl));
        checkOutput({where, ":full"},   32'(full0),  32'(lvl == DEPTH));
        checkOutput({where, ":empty"},  32'(empty0), 32'(lvl == 0));
        checkOutput({where, ":af"},     32'(af0),    32'(lvl >= AF));
        checkOutput({where, ":ae"},     32'(ae0),    32'(lvl <= AE));
        checkOutput({where, ":ovf"},    32'(ovf0),   32'(modelOvf));
        checkOutput({where, ":unf"},    32'(unf0),   32'(modelUnf));
        checkOutput({where, ":dout"},   32'(dout0),  32'(modelDout0));
        checkOutput({where, ":fwLevel"}, 32'(level1), 32'(lvl));
        checkOutput({where, ":fwEmpty"}, 32'(empty1), 32'(lvl == 0));
        checkOutput({where, ":fwOvf"},   32'(ovf1),   32'(modelOvf));
        checkOutput({where, ":fwUnf"},   32'(unf1),   32'(modelUnf));
        checkOutput({where, ":fwDout"},  32'(dout1),  32'(head));
    endtask

    // Drive one cycle of inputs, clock it, advance the model and check
    // one time unit after the edge.
    task automatic applyStimulus(input string where, input logic clr,
                                 input logic w, input logic r,
                                 input logic [DW-1:0] din);
        CLEAR   = clr;
        W_ENA   = w;
        R_ENA   = r;
        DATA_IN = din;
        @(posedge clk);
        modelStep(clr, w, r, din);
        #1;
        CLEAR = 1'b0;
        W_ENA = 1'b0;
        R_ENA = 1'b0;
        checkState(where);
    endtask

    // Directed scenarios followed by a randomized soak.
    initial begin
        logic [DW-1:0] nextByte;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkState("resetHeld");
        reset = 1'b0;
        #2;
        checkState("resetReleased");

        // Fill to full, then one overflowing write
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus("fill", 1'b0, 1'b1, 1'b0, DW'(i * 8'h11));
        end
        applyStimulus("overflowWrite", 1'b0, 1'b1, 1'b0, 8'h99);

        // Drain in order, then one underflowing read
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus("drain", 1'b0, 1'b0, 1'b1, 8'h00);
        end
        applyStimulus("underflowRead", 1'b0, 1'b0, 1'b1, 8'h00);
        applyStimulus("clearFlags", 1'b1, 1'b0, 1'b0, 8'h00);

        // Stream 20 words at level 3 across two pointer wraps
        nextByte = 8'h30;
        for (int i = 0; i < 3; i++) begin
            applyStimulus("preload", 1'b0, 1'b1, 1'b0, nextByte);
            nextByte++;
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus("stream", 1'b0, 1'b1, 1'b1, nextByte);
            nextByte++;
        end

        // Top up to full, then read and write together
        while (modelQ.size() < DEPTH) begin
            applyStimulus("topUp", 1'b0, 1'b1, 1'b0, nextByte);
            nextByte++;
        end
        applyStimulus("bothWhileFull", 1'b0, 1'b1, 1'b1, 8'hEE);

        // Both requested while empty
        applyStimulus("flush", 1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus("bothWhileEmpty", 1'b0, 1'b1, 1'b1, 8'h5A);
        applyStimulus("flush2", 1'b1, 1'b0, 1'b0, 8'h00);

        // Fall-through head appears without a read request
        applyStimulus("fwftWrite", 1'b0, 1'b1, 1'b0, 8'hA5);
        applyStimulus("fwftIdle", 1'b0, 1'b0, 1'b0, 8'h00);

        // Asynchronous reset at level 5, checked before the next edge
        for (int i = 0; i < 4; i++) begin
            applyStimulus("toFive", 1'b0, 1'b1, 1'b0, DW'(8'hC0 + i));
        end
        checkOutput("levelBeforeReset", 32'(level0), 32'd5);
        W_ENA = 1'b1;
        DATA_IN = 8'hDD;
        reset = 1'b1;
        #1;
        modelReset();
        checkState("asyncReset");
        W_ENA = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkState("afterReset");
        applyStimulus("firstWriteAfterReset", 1'b0, 1'b1, 1'b0, 8'h77);
        applyStimulus("readAfterReset", 1'b0, 1'b0, 1'b1, 8'h00);

        // CLEAR at level 5 with a write pending drops the write
        for (int i = 0; i < 5; i++) begin
            applyStimulus("toFiveAgain", 1'b0, 1'b1, 1'b0, DW'(8'h50 + i));
        end
        applyStimulus("clearWithWrite", 1'b1, 1'b1, 1'b0, 8'hFF);

        // Randomized soak with occasional flushes
        for (int i = 0; i < 600; i++) begin
            applyStimulus("random", ($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 99) < 55),
                          ($urandom_range(0, 99) < 50),
                          DW'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
